// File: rtl/tril_matmul_sched.sv
// ---------------------------------------------------------------------------
// tril_matmul_sched
//
// Operation scheduler for C = A*B with A, B lower-triangular N x N. Walks
// only the structurally non-zero work C[i][j] = sum_{k=j..i} A[i][k]*B[k][j]
// for j <= i, issuing one (i, j, k) triple per accepted handshake. Order is
// row-major over (i, j) with k ascending inside each element.
//
// Optional feature (macro TRIL_SCHED_ZERO_FILL_EN): when defined, every
// upper-triangle element (j > i) also gets one write-zero op
// (op_zero = op_first = op_last = 1, op_k = 0) in its row-major slot.
// When undefined, the upper triangle is skipped and op_zero is tied 0.
//
// Handshake: a triple transfers on a rising edge where op_valid && op_ready.
// While op_valid && !op_ready every op_* output holds; op_valid stays high
// for the whole run and never depends combinationally on op_ready.
//
// Ports:
//   clk, rst    single rising-edge clock, synchronous active-high reset
//   start       launch a run (sampled only in IDLE)
//   dim         runtime dimension, latched on accepted start, clamped to N
//   busy        high while in RUN
//   done        one-cycle pulse at end of run
//   op_valid    operand triple valid
//   op_ready    MAC accepts triple
//   op_i/j/k    row, column and reduction index of current triple
//   op_first    clear accumulator before this product
//   op_last     write C[i][j] after this product
//   op_zero     write-zero op for the upper triangle
//   op_cnt      handshakes accepted in current/last run (saturating)
//   state_dbg   current FSM state encoding (IDLE=0, RUN=1, DONE=2)
// ---------------------------------------------------------------------------
module tril_matmul_sched #(
  parameter int N     = 8,
  parameter int IDX_W = $clog2(N),
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [IDX_W:0]   dim,
  output logic             busy,
  output logic             done,
  output logic             op_valid,
  input  logic             op_ready,
  output logic [IDX_W-1:0] op_i,
  output logic [IDX_W-1:0] op_j,
  output logic [IDX_W-1:0] op_k,
  output logic             op_first,
  output logic             op_last,
  output logic             op_zero,
  output logic [CNT_W-1:0] op_cnt,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [IDX_W:0] N_MAX = (IDX_W+1)'(N);

  state_t           state_q, state_d;
  logic [IDX_W:0]   dim_eff_q, dim_eff_d;
  logic [IDX_W:0]   dim_clamp;
  logic [IDX_W-1:0] i_q, j_q, k_q;
  logic [IDX_W-1:0] i_d, j_d, k_d;
  logic [IDX_W-1:0] last_idx;
  logic [IDX_W-1:0] j_inc;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             in_run;
  logic             hs;
  logic             final_op;
  logic             accept_start;
  logic             zero_op;

  assign dim_clamp    = (dim > N_MAX) ? N_MAX : dim;
  assign in_run       = (state_q == RUN);
  assign hs           = in_run && op_ready;
  assign accept_start = (state_q == IDLE) && start;
  // dim_eff is never 0 in RUN, so last_idx is always a valid index there.
  assign last_idx     = IDX_W'(dim_eff_q - 1'b1);
  assign j_inc        = j_q + 1'b1;
  assign final_op     = (i_q == last_idx) && (j_q == last_idx) && (k_q == last_idx);

`ifdef TRIL_SCHED_ZERO_FILL_EN
  assign zero_op = in_run && (j_q > i_q);
`else
  assign zero_op = 1'b0;
`endif

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = (dim == '0) ? DONE : RUN;
      RUN:  if (hs && final_op) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Latched dimension and saturating handshake counter
  always_comb begin
    dim_eff_d = dim_eff_q;
    cnt_d     = cnt_q;
    if (accept_start) begin
      dim_eff_d = dim_clamp;
      cnt_d     = '0;
    end else if (hs && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Index walk. Indices return to 0 after the final op so that idle
  // outputs match the reset values.
  always_comb begin
    i_d = i_q;
    j_d = j_q;
    k_d = k_q;
    if (accept_start) begin
      i_d = '0;
      j_d = '0;
      k_d = '0;
    end else if (hs) begin
      if (final_op) begin
        i_d = '0;
        j_d = '0;
        k_d = '0;
      end
`ifdef TRIL_SCHED_ZERO_FILL_EN
      else if (j_q > i_q) begin
        // Upper triangle: one op per element, then next column or row.
        if (j_q < last_idx) begin
          j_d = j_inc;
          k_d = '0;
        end else begin
          i_d = i_q + 1'b1;
          j_d = '0;
          k_d = '0;
        end
      end else if (k_q < i_q) begin
        k_d = k_q + 1'b1;
      end else if (j_q < last_idx) begin
        // Next column may cross into the upper triangle, where k is 0.
        j_d = j_inc;
        k_d = (j_inc <= i_q) ? j_inc : '0;
      end else begin
        i_d = i_q + 1'b1;
        j_d = '0;
        k_d = '0;
      end
`else
      else if (k_q < i_q) begin
        k_d = k_q + 1'b1;
      end else if (j_q < i_q) begin
        // Reduction for C[i][j] starts at k = j.
        j_d = j_inc;
        k_d = j_inc;
      end else begin
        i_d = i_q + 1'b1;
        j_d = '0;
        k_d = '0;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      dim_eff_q <= '0;
      i_q       <= '0;
      j_q       <= '0;
      k_q       <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      dim_eff_q <= dim_eff_d;
      i_q       <= i_d;
      j_q       <= j_d;
      k_q       <= k_d;
      cnt_q     <= cnt_d;
    end
  end

  assign busy      = in_run;
  assign done      = (state_q == DONE);
  assign op_valid  = in_run;
  assign op_i      = i_q;
  assign op_j      = j_q;
  assign op_k      = k_q;
  assign op_zero   = zero_op;
  assign op_first  = in_run && (zero_op || (k_q == j_q));
  assign op_last   = in_run && (zero_op || (k_q == i_q));
  assign op_cnt    = cnt_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_tril_matmul_sched.sv
// ---------------------------------------------------------------------------
// tb_tril_matmul_sched
//
// Directed bench for tril_matmul_sched (N = 8). Expected triples come from a
// nested-loop reference of the row-major (i, j), k-ascending walk and are
// held in a scoreboard queue; op counts per run are hand-computed constants.
// Inputs change on the falling edge, outputs are sampled there as well.
// ---------------------------------------------------------------------------
module tb_tril_matmul_sched;

  localparam int N     = 8;
  localparam int IDX_W = 3;
  localparam int CNT_W = 16;
  localparam int W     = 12;
  localparam int BUDGET = 2000;

`ifdef TRIL_SCHED_ZERO_FILL_EN
  localparam bit ZF = 1'b1;
`else
  localparam bit ZF = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [IDX_W:0]   dim;
  logic             busy;
  logic             done;
  logic             op_valid;
  logic             op_ready;
  logic [IDX_W-1:0] op_i;
  logic [IDX_W-1:0] op_j;
  logic [IDX_W-1:0] op_k;
  logic             op_first;
  logic             op_last;
  logic             op_zero;
  logic [CNT_W-1:0] op_cnt;
  logic [1:0]       state_dbg;

  always #5 clk = ~clk;

  tril_matmul_sched #(.N(N), .IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dim       (dim),
    .busy      (busy),
    .done      (done),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .op_i      (op_i),
    .op_j      (op_j),
    .op_k      (op_k),
    .op_first  (op_first),
    .op_last   (op_last),
    .op_zero   (op_zero),
    .op_cnt    (op_cnt),
    .state_dbg (state_dbg)
  );

  logic [W-1:0] obs_op;
  assign obs_op = {op_zero, op_first, op_last, op_i, op_j, op_k};

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] pack_op(bit z, bit f, bit l, int i, int j, int k);
    logic [2:0] ii, jj, kk;
    ii = 3'(i);
    jj = 3'(j);
    kk = 3'(k);
    return {z, f, l, ii, jj, kk};
  endfunction

  task automatic build_exp(input int d);
    int eff;
    int jmax;
    eff = (d > N) ? N : d;
    exp_q.delete();
    for (int i = 0; i < eff; i++) begin
      jmax = ZF ? eff : i + 1;
      for (int j = 0; j < jmax; j++) begin
        if (j > i) exp_q.push_back(pack_op(1'b1, 1'b1, 1'b1, i, j, 0));
        else
          for (int k = j; k <= i; k++)
            exp_q.push_back(pack_op(1'b0, k == j, k == i, i, j, k));
      end
    end
  endtask

  // ---------------- driver ----------------
  // Runs one job of dimension d. ready_pct sets op_ready probability;
  // poke_at >= 0 pulses start (with dim = 2) at that cycle of the run.
  task automatic run_case(input int d, input int ready_pct, input int exp_ops, input int poke_at);
    int hs;
    int cyc;
    bit stall;
    logic [W-1:0] prev;
    build_exp(d);
    @(negedge clk);
    start = 1'b1;
    dim   = 4'(d);
    @(negedge clk);
    start = 1'b0;
    hs    = 0;
    cyc   = 0;
    stall = 1'b0;
    prev  = '0;
    if (d == 0) begin
      check_eq("dim0_busy", 32'(busy), 32'd0);
      check_eq("dim0_valid", 32'(op_valid), 32'd0);
    end
    while (!done && cyc < BUDGET) begin
      check_eq("valid_in_run", 32'(op_valid), 32'd1);
      if (stall) check_eq("hold_stable", 32'(obs_op), 32'(prev));
      if (cyc == poke_at) begin
        start = 1'b1;
        dim   = 4'd2;
      end else begin
        start = 1'b0;
      end
      op_ready = ($urandom_range(0, 99) < ready_pct);
      if (op_ready) begin
        hs++;
        if (exp_q.size() == 0) check_eq("extra_op", 32'd1, 32'd0);
        else check_eq("op_triple", 32'(obs_op), 32'(exp_q.pop_front()));
      end
      stall = !op_ready;
      prev  = obs_op;
      @(negedge clk);
      cyc++;
    end
    start    = 1'b0;
    op_ready = 1'b0;
    check_eq("done_seen", 32'(done), 32'd1);
    check_eq("done_busy", 32'(busy), 32'd0);
    check_eq("done_valid", 32'(op_valid), 32'd0);
    check_eq("n_ops", 32'(hs), 32'(exp_ops));
    check_eq("op_cnt", 32'(op_cnt), 32'(exp_ops));
    check_eq("exp_left", 32'(exp_q.size()), 32'd0);
    if (ready_pct >= 100) check_eq("throughput", 32'(cyc), 32'(exp_ops));
    @(negedge clk);
    check_eq("done_width", 32'(done), 32'd0);
    check_eq("idle_cnt_hold", 32'(op_cnt), 32'(exp_ops));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    dim      = '0;
    op_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_valid", 32'(op_valid), 32'd0);
    check_eq("rst_op", 32'(obs_op), 32'd0);
    check_eq("rst_cnt", 32'(op_cnt), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_case(3,  100, ZF ? 13 : 10, -1);
    run_case(4,  30,  ZF ? 26 : 20, -1);
    run_case(0,  100, 0,   -1);
    run_case(1,  100, 1,   -1);
    run_case(15, 100, ZF ? 148 : 120, -1);
    run_case(4,  100, ZF ? 26 : 20, 5);

    // Reset mid-run after 7 handshakes: run is lost, no done.
    @(negedge clk);
    op_ready = 1'b1;
    start    = 1'b1;
    dim      = 4'd4;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    check_eq("pre_rst_cnt", 32'(op_cnt), 32'd7);
    rst = 1'b1;
    @(negedge clk);
    rst      = 1'b0;
    op_ready = 1'b0;
    check_eq("mid_rst_busy", 32'(busy), 32'd0);
    check_eq("mid_rst_valid", 32'(op_valid), 32'd0);
    check_eq("mid_rst_cnt", 32'(op_cnt), 32'd0);
    for (int c = 0; c < 3; c++) begin
      check_eq("mid_rst_no_done", 32'(done), 32'd0);
      @(negedge clk);
    end

    run_case(2, 100, ZF ? 5 : 4, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
